// File: rtl/mips_pkg.sv
// Shared MIPS encodings: opcode constants, ALUop encodings and the decoded control bundle.
// The ALU control unit imports the same ALUop definitions.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_RTYPE = 2'b10
    } alu_op_e;

    typedef struct packed {
        logic    reg_dst;
        logic    alu_src;
        logic    mem_to_reg;
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    branch;
        alu_op_e alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '{reg_dst: 1'b0, alu_src: 1'b0, mem_to_reg: 1'b0,
                                   reg_write: 1'b0, mem_read: 1'b0, mem_write: 1'b0,
                                   branch: 1'b0, alu_op: ALU_ADD};

    // Only these formats actually source a register from the rt field.
    function automatic logic reads_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);
    endfunction

endpackage

// File: rtl/main_ctrl_idex_if.sv
// ID/EX control boundary: IF/ID inputs, hazard stall and the registered ID/EX outputs.
interface main_ctrl_idex_if #(parameter int ILL_CNT_W = 8);
    logic                 id_valid;
    logic [31:0]          id_instr;
    logic                 flush;
    logic                 stall;
    logic                 ex_valid;
    logic [1:0]           ex_ALUop;
    logic [5:0]           ex_funct;
    logic                 ex_RegDst;
    logic                 ex_ALUSrc;
    logic                 ex_MemtoReg;
    logic                 ex_RegWrite;
    logic                 ex_MemRead;
    logic                 ex_MemWrite;
    logic                 ex_Branch;
    logic [4:0]           ex_rs;
    logic [4:0]           ex_rt;
    logic [4:0]           ex_rd;
    logic                 illegal;
    logic [ILL_CNT_W-1:0] ill_cnt;

    modport master (
        output id_valid, id_instr, flush,
        input  stall, ex_valid, ex_ALUop, ex_funct, ex_RegDst, ex_ALUSrc, ex_MemtoReg,
               ex_RegWrite, ex_MemRead, ex_MemWrite, ex_Branch, ex_rs, ex_rt, ex_rd,
               illegal, ill_cnt
    );

    modport slave (
        input  id_valid, id_instr, flush,
        output stall, ex_valid, ex_ALUop, ex_funct, ex_RegDst, ex_ALUSrc, ex_MemtoReg,
               ex_RegWrite, ex_MemRead, ex_MemWrite, ex_Branch, ex_rs, ex_rt, ex_rd,
               illegal, ill_cnt
    );
endinterface

// File: rtl/main_ctrl_idex_decoder.sv
// Combinational main decoder: opcode to control bundle, flagging unknown opcodes.
module main_decoder
    import mips_pkg::*;
(
    input  logic [5:0] opcode_i,
    output ctrl_t      ctrl_o,
    output logic       illegal_o
);

    // Opcode table; anything unlisted decodes as an all-zero bundle and is flagged.
    always_comb begin
        ctrl_o    = CTRL_NOP;
        illegal_o = 1'b0;
        case (opcode_i)
            OP_RTYPE: begin
                ctrl_o.reg_dst   = 1'b1;
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_op    = ALU_RTYPE;
            end
            OP_LW: begin
                ctrl_o.alu_src    = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_read   = 1'b1;
            end
            OP_SW: begin
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.mem_write = 1'b1;
            end
            OP_BEQ: begin
                ctrl_o.branch = 1'b1;
                ctrl_o.alu_op = ALU_SUB;
            end
            OP_ADDI: begin
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.reg_write = 1'b1;
            end
            default: begin
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/main_ctrl_idex.sv
// ID-stage control: load-use hazard detection, ID/EX pipeline register and
// a saturating illegal-opcode counter.
module main_ctrl_idex
    import mips_pkg::*;
#(
    parameter int ILL_CNT_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    main_ctrl_idex_if.slave bus
);

    logic [5:0]           opcode_s;
    logic [4:0]           rs_s, rt_s, rd_s;
    ctrl_t                dec_ctrl_s;
    logic                 dec_illegal_s;
    logic                 stall_s, issue_s, count_s;

    ctrl_t                ctrl_q, ctrl_d;
    logic                 ex_valid_q, ex_valid_d;
    logic [5:0]           ex_funct_q, ex_funct_d;
    logic [4:0]           ex_rs_q, ex_rt_q, ex_rd_q;
    logic                 illegal_q;
    logic [ILL_CNT_W-1:0] ill_cnt_q, ill_cnt_d;

    assign opcode_s = bus.id_instr[31:26];
    assign rs_s     = bus.id_instr[25:21];
    assign rt_s     = bus.id_instr[20:16];
    assign rd_s     = bus.id_instr[15:11];

    main_decoder u_dec (
        .opcode_i  (opcode_s),
        .ctrl_o    (dec_ctrl_s),
        .illegal_o (dec_illegal_s)
    );

    // Load-use detection and ID/EX next-state; flush overrides both stall and decode.
    always_comb begin
        stall_s = 1'b0;
        if (!bus.flush && ex_valid_q && ctrl_q.mem_read && bus.id_valid &&
            (ex_rt_q != 5'd0) &&
            ((ex_rt_q == rs_s) || ((ex_rt_q == rt_s) && reads_rt(opcode_s)))) begin
            stall_s = 1'b1;
        end else begin
            stall_s = 1'b0;
        end

        issue_s    = bus.id_valid && !bus.flush && !stall_s;
        count_s    = issue_s && dec_illegal_s;
        ex_valid_d = issue_s && !dec_illegal_s;

        if (ex_valid_d) begin
            ctrl_d     = dec_ctrl_s;
            ex_funct_d = bus.id_instr[5:0];
        end else begin
            ctrl_d     = CTRL_NOP;
            ex_funct_d = 6'd0;
        end

        // A stalled illegal instruction is re-presented next cycle, so it is counted once.
        if (count_s && (ill_cnt_q != {ILL_CNT_W{1'b1}})) begin
            ill_cnt_d = ill_cnt_q + {{(ILL_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            ill_cnt_d = ill_cnt_q;
        end
    end

    // ID/EX register and illegal-opcode bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q     <= CTRL_NOP;
            ex_valid_q <= 1'b0;
            ex_funct_q <= 6'd0;
            ex_rs_q    <= 5'd0;
            ex_rt_q    <= 5'd0;
            ex_rd_q    <= 5'd0;
            illegal_q  <= 1'b0;
            ill_cnt_q  <= {ILL_CNT_W{1'b0}};
        end else begin
            ctrl_q     <= ctrl_d;
            ex_valid_q <= ex_valid_d;
            ex_funct_q <= ex_funct_d;
            ex_rs_q    <= rs_s;
            ex_rt_q    <= rt_s;
            ex_rd_q    <= rd_s;
            illegal_q  <= count_s;
            ill_cnt_q  <= ill_cnt_d;
        end
    end

    assign bus.stall       = stall_s;
    assign bus.ex_valid    = ex_valid_q;
    assign bus.ex_ALUop    = ctrl_q.alu_op;
    assign bus.ex_funct    = ex_funct_q;
    assign bus.ex_RegDst   = ctrl_q.reg_dst;
    assign bus.ex_ALUSrc   = ctrl_q.alu_src;
    assign bus.ex_MemtoReg = ctrl_q.mem_to_reg;
    assign bus.ex_RegWrite = ctrl_q.reg_write;
    assign bus.ex_MemRead  = ctrl_q.mem_read;
    assign bus.ex_MemWrite = ctrl_q.mem_write;
    assign bus.ex_Branch   = ctrl_q.branch;
    assign bus.ex_rs       = ex_rs_q;
    assign bus.ex_rt       = ex_rt_q;
    assign bus.ex_rd       = ex_rd_q;
    assign bus.illegal     = illegal_q;
    assign bus.ill_cnt     = ill_cnt_q;

endmodule

// File: tb/tb_main_ctrl_idex.sv
// Scoreboard bench for main_ctrl_idex: directed vectors push expectations, a negedge monitor checks.
module tb_main_ctrl_idex;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    main_ctrl_idex_if #(.ILL_CNT_W(8)) bus ();
    main_ctrl_idex #(.ILL_CNT_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // Control bit order: RegDst ALUSrc MemtoReg RegWrite MemRead MemWrite Branch
    localparam logic [6:0] C_R    = 7'b1001000;
    localparam logic [6:0] C_LW   = 7'b0111100;
    localparam logic [6:0] C_SW   = 7'b0100010;
    localparam logic [6:0] C_BEQ  = 7'b0000001;
    localparam logic [6:0] C_ADDI = 7'b0101000;

    localparam logic [31:0] I_LW   = 32'h8E28_0004; // lw   $t0, 4($s1)      rt=8
    localparam logic [31:0] I_ADD  = 32'h010A_4820; // add  $t1, $t0, $t2    rs=8
    localparam logic [31:0] I_BEQ  = 32'h1022_0010; // beq  $1, $2, 16
    localparam logic [31:0] I_LW0  = 32'h8E20_0004; // lw   $0, 4($s1)       rt=0
    localparam logic [31:0] I_ADD0 = 32'h0000_4820; // add  $t1, $0, $0
    localparam logic [31:0] I_ADDI = 32'h2128_0005; // addi $t0, $t1, 5
    localparam logic [31:0] I_SW   = 32'hAFA8_0008; // sw   $t0, 8($sp)
    localparam logic [31:0] I_ILL  = 32'hFC00_0000; // opcode 111111

    typedef struct packed {
        logic       v;
        logic [6:0] c;
        logic [1:0] alu;
        logic [5:0] funct;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic       ill;
        logic [7:0] cnt;
    } exp_t;

    exp_t qe[$];
    int   qe_tag[$];
    logic qs[$];
    int   qs_tag[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    logic [7:0] exp_cnt = 8'd0;

    function automatic exp_t observe();
        exp_t a;
        a = '{v: bus.ex_valid,
              c: {bus.ex_RegDst, bus.ex_ALUSrc, bus.ex_MemtoReg, bus.ex_RegWrite,
                  bus.ex_MemRead, bus.ex_MemWrite, bus.ex_Branch},
              alu: bus.ex_ALUop, funct: bus.ex_funct,
              rs: bus.ex_rs, rt: bus.ex_rt, rd: bus.ex_rd,
              ill: bus.illegal, cnt: bus.ill_cnt};
        return a;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h want %h", nm, cyc, got, want);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares whatever expectations fall due at this cycle.
    always @(negedge clk) begin
        if (qs.size() > 0 && qs_tag[0] == cyc) begin
            chk("stall", {63'd0, bus.stall}, {63'd0, qs[0]});
            void'(qs.pop_front());
            void'(qs_tag.pop_front());
        end
        if (qe.size() > 0 && qe_tag[0] == cyc) begin
            chk("idex_regs", {24'd0, observe()}, {24'd0, qe[0]});
            void'(qe.pop_front());
            void'(qe_tag.pop_front());
        end
    end

    task automatic step(input logic v, input logic [31:0] ins, input logic fl,
                        input logic st, input logic ev, input logic [6:0] c,
                        input logic [1:0] alu, input logic ill);
        exp_t e;
        @(posedge clk);
        #1;
        bus.id_valid = v;
        bus.id_instr = ins;
        bus.flush    = fl;
        if (ill && exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
        e = '{v: ev, c: c, alu: alu, funct: (ev ? ins[5:0] : 6'd0),
              rs: ins[25:21], rt: ins[20:16], rd: ins[15:11], ill: ill, cnt: exp_cnt};
        qs.push_back(st);
        qs_tag.push_back(cyc);
        qe.push_back(e);
        qe_tag.push_back(cyc + 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.id_valid = 1'b0;
        bus.id_instr = 32'd0;
        bus.flush    = 1'b0;
        #2;
        chk("reset_outputs", {24'd0, observe()}, 64'd0);
        chk("reset_stall", {63'd0, bus.stall}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Load-use: one stall cycle, one bubble, then the add issues
        step(1'b1, I_LW,   1'b0, 1'b0, 1'b1, C_LW,   2'b00, 1'b0);
        step(1'b1, I_ADD,  1'b0, 1'b1, 1'b0, 7'd0,   2'b00, 1'b0);
        step(1'b1, I_ADD,  1'b0, 1'b0, 1'b1, C_R,    2'b10, 1'b0);
        step(1'b1, I_BEQ,  1'b0, 1'b0, 1'b1, C_BEQ,  2'b01, 1'b0);
        // Flush coinciding with load-use
        step(1'b1, I_LW,   1'b0, 1'b0, 1'b1, C_LW,   2'b00, 1'b0);
        step(1'b1, I_ADD,  1'b1, 1'b0, 1'b0, 7'd0,   2'b00, 1'b0);
        step(1'b0, I_ADD,  1'b0, 1'b0, 1'b0, 7'd0,   2'b00, 1'b0);
        // Load to $0 never creates a hazard
        step(1'b1, I_LW0,  1'b0, 1'b0, 1'b1, C_LW,   2'b00, 1'b0);
        step(1'b1, I_ADD0, 1'b0, 1'b0, 1'b1, C_R,    2'b10, 1'b0);
        // addi writes rt, so matching rt is not a hazard
        step(1'b1, I_LW,   1'b0, 1'b0, 1'b1, C_LW,   2'b00, 1'b0);
        step(1'b1, I_ADDI, 1'b0, 1'b0, 1'b1, C_ADDI, 2'b00, 1'b0);
        // Illegal opcodes under flush / invalid are not counted
        step(1'b1, I_ILL,  1'b1, 1'b0, 1'b0, 7'd0,   2'b00, 1'b0);
        step(1'b0, I_ILL,  1'b0, 1'b0, 1'b0, 7'd0,   2'b00, 1'b0);
        for (int i = 0; i < 300; i++) begin
            step(1'b1, I_ILL, 1'b0, 1'b0, 1'b0, 7'd0, 2'b00, 1'b1);
        end
        step(1'b1, I_SW,   1'b0, 1'b0, 1'b1, C_SW,   2'b00, 1'b0);
        chk("ill_cnt_saturated", {56'd0, exp_cnt}, 64'd255);

        // Reset mid-stream with a load in EX and a dependent add in ID
        step(1'b1, I_LW,   1'b0, 1'b0, 1'b1, C_LW,   2'b00, 1'b0);
        @(posedge clk);
        #2;
        qs.delete();
        qs_tag.delete();
        qe.delete();
        qe_tag.delete();
        bus.id_instr = I_ADD;
        bus.id_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {24'd0, observe()}, 64'd0);
        chk("async_reset_stall", {63'd0, bus.stall}, 64'd0);
        bus.id_valid = 1'b0;
        exp_cnt = 8'd0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, I_SW,   1'b0, 1'b0, 1'b1, C_SW,   2'b00, 1'b0);
        step(1'b0, 32'd0,  1'b0, 1'b0, 1'b0, 7'd0,   2'b00, 1'b0);
        repeat (3) @(posedge clk);
        #6;
        chk("scoreboard_drained", 64'(qe.size() + qs.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/main_ctrl_idex.md
MAIN_CTRL_IDEX -- requirements
Module: main_ctrl_idex

Interface
REQ-001 SHALL have parameter ILL_CNT_W, default 8: width of the saturating illegal-opcode counter.
REQ-002 SHALL have port clk  in  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have port id_valid  in  1  the IF/ID register holds a real instruction.
REQ-005 SHALL have port id_instr  in  32  IF/ID instruction word.
REQ-006 SHALL have port flush  in  1  branch-taken squash from EX.
REQ-007 SHALL have port stall  out  1  combinational; hold PC and IF/ID this cycle.
REQ-008 SHALL have port ex_valid  out  1  ID/EX holds a real instruction.
REQ-009 SHALL have port ex_ALUop  out  2  ALUop for the downstream ALU control unit.
REQ-010 SHALL have port ex_funct  out  6  instr[5:0], passed through.
REQ-011 SHALL have ports ex_RegDst, ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_Branch  out  1 each  registered control bits.
REQ-012 SHALL have ports ex_rs, ex_rt, ex_rd  out  5 each  registered register fields.
REQ-013 SHALL have port illegal  out  1  registered; last decoded instruction had an unknown opcode.
REQ-014 SHALL have port ill_cnt  out  ILL_CNT_W  saturating count of illegal opcodes.

Function
REQ-015 SHALL decode opcode = instr[31:26] as follows: 000000 R-type: RegDst=1, RegWrite=1, ALUop=10. 100011 lw: ALUSrc=1, MemtoReg=1, RegWrite=1, MemRead=1, ALUop=00. 101011 sw: ALUSrc=1, MemWrite=1, ALUop=00. 000100 beq: Branch=1, ALUop=01. 001000 addi: ALUSrc=1, RegWrite=1, ALUop=00. All bits not listed SHALL be 0.
REQ-016 SHALL treat any other opcode as illegal: the instruction is registered as a bubble, illegal=1 for one cycle, and ill_cnt is incremented.
REQ-017 SHALL hold ill_cnt at all-ones once it saturates; it SHALL never wrap.
REQ-018 SHALL assert stall (load-use) when ex_valid & ex_MemRead & id_valid & ex_rt!=0 & (ex_rt==instr[25:21] | (ex_rt==instr[20:16] & opcode in {R-type, sw, beq})).
REQ-019 SHALL define a bubble as ex_valid=0 with every control bit, ex_ALUop and ex_funct at 0.
REQ-020 SHALL load a bubble into ID/EX on a cycle with stall=1; the IF/ID contents are held by the upstream stage.
REQ-021 SHALL load a bubble into ID/EX when flush=1; flush takes priority over stall and over decode; stall SHALL be forced to 0 while flush=1.
REQ-022 SHALL load a bubble when id_valid=0.
REQ-023 SHALL otherwise register the decoded instruction with a latency of exactly one clock (decode in cycle N, visible on ex_* in cycle N+1) and set ex_valid=1.
REQ-024 SHALL register ex_rs, ex_rt and ex_rd from instr[25:21], instr[20:16] and instr[15:11] regardless of validity.
REQ-025 SHALL not count an illegal opcode when flush=1 or id_valid=0.
REQ-026 SHALL never hold stall high for two consecutive cycles for the same load, because the bubble clears ex_MemRead.

Reset
REQ-027 SHALL, while rst_n=0, immediately clear every registered output, including ill_cnt and illegal, to 0; stall SHALL be 0 during reset.
REQ-028 SHALL discard an instruction in flight when reset is asserted mid-operation; the first instruction after release SHALL decode normally.

Structure
REQ-029 SHALL take the opcode constants and the ALUop encodings (ADD=00, SUB=01, RTYPE=10) from the shared package mips_pkg, which the ALU control unit also uses.
REQ-030 SHALL implement opcode decoding as a combinational sub-module main_decoder; hazard detection and the ID/EX register SHALL be in the top module.

Verification
REQ-031 SHALL verify: lw $t0 (opcode 100011, rt=8), then R-type add reading rs=8 -> stall=1 for exactly one cycle, one bubble, then the add is registered with ex_ALUop=10.
REQ-032 SHALL verify: beq (000100) -> next cycle ex_Branch=1, ex_ALUop=01, ex_valid=1, with all other control bits 0.
REQ-033 SHALL verify: flush=1 coinciding with a load-use condition -> stall=0 and a bubble is registered.
REQ-034 SHALL verify: 300 consecutive illegal opcodes (111111) with ILL_CNT_W=8 -> ill_cnt=255, held at that value, and ex_valid=0 throughout.
REQ-035 SHALL verify: lw with rt=0 followed by an instruction reading $0 -> no stall.
REQ-036 SHALL verify: rst_n taken low mid-stream -> all outputs are 0 asynchronously, and after release sw is decoded as ALUSrc=1, MemWrite=1, ALUop=00.
